// File: rtl/booth_datapath_pkg.sv
// Shared constants for the Booth multiplier datapath and its controller.
// Combinational helpers only. No latency and no backpressure.
package booth_pkg;
    localparam int DEF_WIDTH = 16;

    function automatic int cw_of(input int width);
        return $clog2(width + 1);
    endfunction

    // The Booth pair is {Q[0], Q[-1]}.
    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;
endpackage

// File: rtl/booth_datapath_if.sv
// Links the Booth controller (master) to the datapath (slave): strobes go one way, status comes back.
// Wires only. No latency and no backpressure.
interface booth_datapath_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0]   data_in;
    logic               ldA, clrA, sftA;
    logic               ldQ, clrQ, sftQ;
    logic               ldM, clrff, addsub;
    logic               ldcount, decount, done;
    logic               q0, qd, stop;
    logic [2*WIDTH-1:0] product;
    logic               product_valid;

    modport master (
        output data_in, ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub,
               ldcount, decount, done,
        input  q0, qd, stop, product, product_valid
    );

    modport slave (
        input  data_in, ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub,
               ldcount, decount, done,
        output q0, qd, stop, product, product_valid
    );
endinterface

// File: rtl/booth_datapath_addsub.sv
// Combinational W-bit adder/subtractor for the Booth accumulator.
// Zero latency. No backpressure.
module booth_addsub
    import booth_pkg::*;
#(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         addsub,
    output logic [W-1:0] sum
);
    assign sum = (addsub == OP_ADD) ? a + b : a - b;
endmodule

// File: rtl/booth_datapath.sv
// Booth multiplier registers (A, Q, M, Q[-1], count). Each strobe acts on the next clock edge.
// product_valid follows done one cycle later. Strobes are always obeyed; there is no backpressure.
module booth_datapath
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    booth_datapath_if.slave  bus
);
    localparam int CW = cw_of(WIDTH);

    // A carries one guard bit so that A - M with M = -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   alu;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic             qd_q;
    logic [CW-1:0]    cnt_q;
    logic             pv_q;

    booth_addsub #(.W(WIDTH + 1)) u_addsub (
        .a      (a_q),
        .b      ({m_q[WIDTH-1], m_q}),
        .addsub (bus.addsub),
        .sum    (alu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            q_q   <= '0;
            m_q   <= '0;
            qd_q  <= 1'b0;
            cnt_q <= '0;
            pv_q  <= 1'b0;
        end else begin
            if (bus.clrA)      a_q <= '0;
            else if (bus.ldA)  a_q <= alu;
            else if (bus.sftA) a_q <= {a_q[WIDTH], a_q[WIDTH:1]};

            // The serial-in bit is the pre-shift A[0], so a joint A/Q shift stays correct.
            if (bus.clrQ)      q_q <= '0;
            else if (bus.ldQ)  q_q <= bus.data_in;
            else if (bus.sftQ) q_q <= {a_q[0], q_q[WIDTH-1:1]};

            if (bus.ldM) m_q <= bus.data_in;

            if (bus.clrff)     qd_q <= 1'b0;
            else if (bus.sftQ) qd_q <= q_q[0];

            // The counter saturates at zero so that stop stays asserted.
            if (bus.ldcount)                     cnt_q <= CW'(WIDTH);
            else if (bus.decount && cnt_q != '0) cnt_q <= cnt_q - CW'(1);

            pv_q <= bus.done;
        end
    end

    assign bus.q0            = q_q[0];
    assign bus.qd            = qd_q;
    assign bus.stop          = (cnt_q == '0);
    assign bus.product       = {a_q[WIDTH-1:0], q_q};
    assign bus.product_valid = pv_q;
endmodule

// File: doc/booth_datapath.md
Name: booth_datapath

Overview:
- Datapath stage driven directly by the Booth multiplier controller. Consumes the controller's load, clear, shift, addsub and count strobes.
- Holds the accumulator A, multiplier Q, multiplicand M, the Q[-1] flip-flop and the iteration counter. Returns q0, qd and stop to the controller.
- Presents the signed 2*WIDTH product once the controller asserts done.

Parameters:
WIDTH, 16, operand width in bits (two's complement); must be >= 2
CW, $clog2(WIDTH+1), counter width (derived localparam, not overridable)

Ports:
clk      input   1        rising-edge clock
rst      input   1        asynchronous, active-high reset
data_in  input   WIDTH    shared operand bus; sampled into M on ldM, into Q on ldQ
ldA      input   1        load A from adder/subtractor result
clrA     input   1        clear A
sftA     input   1        arithmetic right shift of A
ldQ      input   1        load Q from data_in
clrQ     input   1        clear Q
sftQ     input   1        right shift of Q; serial-in is A[0]
ldM      input   1        load M from data_in
clrff    input   1        clear the qd flip-flop
addsub   input   1        1: A+M, 0: A-M
ldcount  input   1        load counter with WIDTH
decount  input   1        decrement counter
done     input   1        controller finished; qualifies product_valid
q0       output  1        Q[0], combinational
qd       output  1        Q[-1] flip-flop
stop     output  1        counter == 0, combinational
product  output  2*WIDTH  {A[WIDTH-1:0], Q}, combinational from registers
product_valid output 1    registered copy of done

Behaviour:
- Reset (async, immediate): A=0, Q=0, M=0, qd=0, count=0, product_valid=0. Outputs become product=0, q0=0, qd=0, stop=1.
- A is WIDTH+1 bits internally, sign-extended. This keeps A-M with M = -2^(WIDTH-1) from overflowing. The ALU is combinational: alu = addsub ? A + sext(M) : A - sext(M).
- Per-register priority within one edge is clear > load > shift. Example: clrA with sftA gives A=0. The same rule applies to Q.
- A shift: A <= {A[WIDTH], A[WIDTH:1]}, i.e. arithmetic, MSB replicated.
- Q shift: Q <= {A[0], Q[WIDTH-1:1]}. It uses the pre-shift A[0], so it stays correct when sftA is asserted in the same cycle.
- qd update:
  - clrff: qd <= 0.
  - sftQ (without clrff): qd <= Q[0], the pre-shift value.
  - Otherwise qd holds.
- Counter:
  - ldcount: count <= WIDTH.
  - decount: count <= count-1, saturating at 0 with no wrap.
  - ldcount wins over decount.
- stop = (count == 0). It is 1 after reset, so the controller must load the counter before it tests stop.
- product_valid <= done every cycle, i.e. one-cycle latency.
- product is defined only while product_valid=1. Any ldA, sftA or sftQ while product_valid=1 is a controller error; the datapath still obeys the strobe.
- Per iteration: one add/sub edge (ldA) for Booth pair 01 (add) or 10 (sub), then one shift edge (sftA+sftQ+decount). Total latency from ldQ is at most 2*WIDTH+1 edges.
- No internal FSM beyond the counter; sequencing belongs to the controller.
- Reset mid-operation aborts the multiply and returns all state to reset values. The datapath holds no memory of the aborted job.

Decomposition:
- Shared package booth_pkg holds:
  - WIDTH default
  - CW computation function
  - Booth pair encoding constants: PAIR_ADD=2'b01, PAIR_SUB=2'b10
  - addsub encoding constants: OP_ADD=1, OP_SUB=0
- One natural sub-module is booth_addsub: combinational (WIDTH+1)-bit adder/subtractor. Registers stay in booth_datapath.

Test Plan:
- Reset mid-run: after several iterations, pulse rst asynchronously between edges -> all outputs zero immediately, stop=1, product_valid=0.
- Bench emulating the controller, WIDTH=8, M=7, Q=-3 -> after done, product=16'hFFEB (-21), product_valid one cycle after done.
- WIDTH=8, M=-128, Q=-128 -> product=16'h4000 (16384); confirms the WIDTH+1 accumulator does not overflow.
- WIDTH=8, M=0x7F, Q=0x7F -> 16'h3F01; M=-1, Q=1 -> 16'hFFFF; M=0 with any Q -> 0.
- Priority: clrA+ldA+sftA on one edge -> A=0. ldcount+decount -> count=WIDTH. clrff+sftQ -> qd=0.
- Counter: ldcount, then WIDTH+3 decount pulses -> stop rises after exactly WIDTH pulses, count stays 0 with no wrap.
